interrupt_priority_arbiter: RTL and testbench

INTERRUPT_PRIORITY_ARBITER -- requirements
Module: interrupt_priority_arbiter

---
 rtl/interrupt_priority_arbiter_if.sv | 64 ++++++
 rtl/interrupt_priority_arbiter.sv | 135 +++++++++++++
 tb/tb_interrupt_priority_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/interrupt_priority_arbiter_if.sv
// Signal bundle between an interrupt controller front end and the
// priority arbiter: request pins, configuration, acknowledge strobes
// and the arbiter's status outputs.
interface interrupt_priority_arbiter_if;
    logic [7:0] interrupt_request_pin;
    logic       level_or_edge_triggered_config;
    logic       special_fully_nest_config;
    logic       write_initial_command_word_1;
    logic [7:0] interrupt_mask;
    logic [7:0] interrupt_special_mask;
    logic       special_mask_mode;
    logic [2:0] priority_rotate;
    logic       freeze;
    logic       latch_in_service;
    logic [7:0] clear_interrupt_request;
    logic [7:0] end_of_interrupt;
    logic [7:0] interrupt;
    logic       interrupt_pending;
    logic [7:0] highest_level_in_service;
    logic [7:0] interrupt_request_register;
    logic [7:0] in_service_register;

    // Controller side: drives requests and configuration, observes status
    modport master (
        output interrupt_request_pin,
        output level_or_edge_triggered_config,
        output special_fully_nest_config,
        output write_initial_command_word_1,
        output interrupt_mask,
        output interrupt_special_mask,
        output special_mask_mode,
        output priority_rotate,
        output freeze,
        output latch_in_service,
        output clear_interrupt_request,
        output end_of_interrupt,
        input  interrupt,
        input  interrupt_pending,
        input  highest_level_in_service,
        input  interrupt_request_register,
        input  in_service_register
    );

    // Arbiter side
    modport slave (
        input  interrupt_request_pin,
        input  level_or_edge_triggered_config,
        input  special_fully_nest_config,
        input  write_initial_command_word_1,
        input  interrupt_mask,
        input  interrupt_special_mask,
        input  special_mask_mode,
        input  priority_rotate,
        input  freeze,
        input  latch_in_service,
        input  clear_interrupt_request,
        input  end_of_interrupt,
        output interrupt,
        output interrupt_pending,
        output highest_level_in_service,
        output interrupt_request_register,
        output in_service_register
    );
endinterface

// File: rtl/interrupt_priority_arbiter.sv
// 8-line interrupt priority arbiter in the style of an 8259 core.
// Holds the request (IRR) and in-service (ISR) registers and registers a
// one-hot winner among unmasked requests that out-rank the in-service level.
// Priority is rotating: priority_rotate names the lowest level, the level
// after it (mod 8) is the highest.  Internally vectors are "normalised" so
// that bit 0 is the highest priority, which turns every priority question
// into a find-lowest-set-bit.
module interrupt_priority_arbiter (
    input  logic                               clock,
    input  logic                               reset_n,
    interrupt_priority_arbiter_if.slave        bus
);

    logic [7:0] prev_pin;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] interrupt_q;

    logic [7:0] prev_pin_next;
    logic [7:0] irr_next;
    logic [7:0] isr_next;
    logic [7:0] interrupt_next;

    logic [7:0] irr_set;
    logic [7:0] irr_clear;
    logic [7:0] eligible_n;
    logic [7:0] blocking_n;
    logic [7:0] block_top_n;
    logic [7:0] allowed_n;
    logic [7:0] winner_n;
    logic [7:0] winner;

    // Reorder so bit k holds physical line (rotate + 1 + k) mod 8
    function automatic logic [7:0] to_normal(input logic [7:0] v, input logic [2:0] rot);
        logic [7:0] r;
        logic [2:0] idx;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx  = rot + 3'd1 + k[2:0];
            r[k] = v[idx];
        end
        return r;
    endfunction

    // Inverse of to_normal
    function automatic logic [7:0] to_physical(input logic [7:0] v, input logic [2:0] rot);
        logic [7:0] r;
        logic [2:0] idx;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx    = rot + 3'd1 + k[2:0];
            r[idx] = v[k];
        end
        return r;
    endfunction

    // Isolate the lowest set bit, i.e. the highest priority in normalised order
    function automatic logic [7:0] lowest_one(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    // Request capture: edge or level sets, with clears taking precedence
    always_comb begin
        irr_set       = 8'h00;
        irr_clear     = bus.clear_interrupt_request;
        prev_pin_next = bus.interrupt_request_pin;
        if (!bus.freeze) begin
            if (bus.level_or_edge_triggered_config)
                irr_set = bus.interrupt_request_pin;
            else
                irr_set = bus.interrupt_request_pin & ~prev_pin;
        end
        if (bus.level_or_edge_triggered_config)
            irr_clear = irr_clear | (~bus.interrupt_request_pin & ~isr);
        irr_next = (irr | irr_set) & ~irr_clear;
        if (bus.write_initial_command_word_1) begin
            irr_next      = 8'h00;
            prev_pin_next = 8'h00;
        end
    end

    // Winner selection: unmasked requests that out-rank the top in-service level
    always_comb begin
        eligible_n = to_normal(irr & ~bus.interrupt_mask, bus.priority_rotate);
        if (bus.special_mask_mode)
            blocking_n = to_normal(isr & ~bus.interrupt_special_mask, bus.priority_rotate);
        else
            blocking_n = to_normal(isr, bus.priority_rotate);
        block_top_n = lowest_one(blocking_n);
        if (block_top_n == 8'h00)
            allowed_n = 8'hFF;
        else
            allowed_n = (block_top_n - 8'd1) |
                        (bus.special_fully_nest_config ? block_top_n : 8'h00);
        winner_n = lowest_one(eligible_n & allowed_n);
        winner   = to_physical(winner_n, bus.priority_rotate);
    end

    // Interrupt output and in-service updates; reinitialise overrides everything
    always_comb begin
        interrupt_next = winner;
        if (bus.latch_in_service || bus.freeze)
            interrupt_next = interrupt_q;
        isr_next = isr & ~bus.end_of_interrupt;
        if (bus.latch_in_service)
            isr_next = isr_next | interrupt_q;
        if (bus.write_initial_command_word_1) begin
            interrupt_next = 8'h00;
            isr_next       = 8'h00;
        end
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_pin    <= 8'h00;
            irr         <= 8'h00;
            isr         <= 8'h00;
            interrupt_q <= 8'h00;
        end else begin
            prev_pin    <= prev_pin_next;
            irr         <= irr_next;
            isr         <= isr_next;
            interrupt_q <= interrupt_next;
        end
    end

    assign bus.interrupt                  = interrupt_q;
    assign bus.interrupt_pending          = |interrupt_q;
    assign bus.interrupt_request_register = irr;
    assign bus.in_service_register        = isr;
    assign bus.highest_level_in_service   =
        to_physical(lowest_one(to_normal(isr, bus.priority_rotate)), bus.priority_rotate);

endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// Directed, table-driven bench for interrupt_priority_arbiter.  Each table
// row is one clock of inputs plus the register/output values expected just
// after that edge; rows form one continuous scenario starting from reset.
module tb_interrupt_priority_arbiter;

    logic clock;
    logic reset_n;
    int   checks_total;
    int   checks_passed;

    interrupt_priority_arbiter_if arb_bus();

    interrupt_priority_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (arb_bus)
    );

    // 10 time-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Safety net so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish (actual running, required finished)");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic [7:0] pin;
        logic       level;
        logic       sfnm;
        logic [7:0] mask;
        logic [7:0] smask;
        logic       smm;
        logic [2:0] rot;
        logic       frz;
        logic       lis;
        logic [7:0] clr;
        logic [7:0] eoi;
        logic       icw1;
        logic [7:0] e_irr;
        logic [7:0] e_isr;
        logic [7:0] e_int;
        logic [7:0] e_hlis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [7:0] pin, input logic level, input logic sfnm,
        input logic [7:0] mask, input logic [7:0] smask, input logic smm,
        input logic [2:0] rot, input logic frz, input logic lis,
        input logic [7:0] clr, input logic [7:0] eoi, input logic icw1,
        input logic [7:0] e_irr, input logic [7:0] e_isr,
        input logic [7:0] e_int, input logic [7:0] e_hlis);
        vec_t v;
        v.pin = pin;   v.level = level; v.sfnm = sfnm; v.mask = mask;
        v.smask = smask; v.smm = smm;   v.rot = rot;   v.frz = frz;
        v.lis = lis;   v.clr = clr;     v.eoi = eoi;   v.icw1 = icw1;
        v.e_irr = e_irr; v.e_isr = e_isr; v.e_int = e_int; v.e_hlis = e_hlis;
        return v;
    endfunction

    // Drive one row of inputs, let one edge pass, settle just after it
    task automatic applyStimulus(input vec_t v);
        arb_bus.interrupt_request_pin          = v.pin;
        arb_bus.level_or_edge_triggered_config = v.level;
        arb_bus.special_fully_nest_config      = v.sfnm;
        arb_bus.interrupt_mask                 = v.mask;
        arb_bus.interrupt_special_mask         = v.smask;
        arb_bus.special_mask_mode              = v.smm;
        arb_bus.priority_rotate                = v.rot;
        arb_bus.freeze                         = v.frz;
        arb_bus.latch_in_service               = v.lis;
        arb_bus.clear_interrupt_request        = v.clr;
        arb_bus.end_of_interrupt               = v.eoi;
        arb_bus.write_initial_command_word_1   = v.icw1;
        @(posedge clock);
        #1;
    endtask

    task automatic compareValue(input string name, input logic [7:0] actual,
                                input logic [7:0] required);
        checks_total++;
        if (actual !== required)
            $display("[TB] FAIL %s: actual %02h, required %02h", name, actual, required);
        else
            checks_passed++;
    endtask

    // Compare every observable output against the row's expectations
    task automatic checkOutput(input vec_t v, input string name);
        compareValue({name, ".irr"},  arb_bus.interrupt_request_register, v.e_irr);
        compareValue({name, ".isr"},  arb_bus.in_service_register,        v.e_isr);
        compareValue({name, ".int"},  arb_bus.interrupt,                  v.e_int);
        compareValue({name, ".hlis"}, arb_bus.highest_level_in_service,   v.e_hlis);
        compareValue({name, ".pend"}, {7'd0, arb_bus.interrupt_pending},  {7'd0, |v.e_int});
    endtask

    task automatic checkAllClear(input string name);
        compareValue({name, ".irr"},  arb_bus.interrupt_request_register, 8'h00);
        compareValue({name, ".isr"},  arb_bus.in_service_register,        8'h00);
        compareValue({name, ".int"},  arb_bus.interrupt,                  8'h00);
        compareValue({name, ".pend"}, {7'd0, arb_bus.interrupt_pending},  8'h00);
    endtask

    // Main scenario
    initial begin
        vec_t h;
        checks_total  = 0;
        checks_passed = 0;
        reset_n = 1'b0;
        h = mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h00,8'h00,8'h00,8'h00);
        applyStimulus(h);
        applyStimulus(h);
        checkAllClear("reset");
        #2 reset_n = 1'b1;

        //         pin   lv sf mask   smask  smm rot  frz lis clr    eoi    icw | irr   isr   int   hlis
        vecs.push_back(mk(8'h0A,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h0A,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h0A,8'h00,8'h02,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,1,8'h02,8'h00,0, 8'h08,8'h02,8'h02,8'h02));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h08,8'h02,8'h00,8'h02));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h02,1,3'd7,0,0,8'h00,8'h00,0, 8'h08,8'h02,8'h08,8'h02));
        vecs.push_back(mk(8'h01,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h09,8'h02,8'h00,8'h02));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h09,8'h02,8'h01,8'h02));
        vecs.push_back(mk(8'h00,0,0,8'h01,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h09,8'h02,8'h00,8'h02));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h02,0, 8'h09,8'h00,8'h01,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd2,0,0,8'h00,8'h00,0, 8'h09,8'h00,8'h08,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h09,8'h00,0, 8'h00,8'h00,8'h01,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h00,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h11,0,0,8'h00,8'h00,0,3'd3,0,0,8'h00,8'h00,0, 8'h11,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd3,0,0,8'h00,8'h00,0, 8'h11,8'h00,8'h10,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd4,0,0,8'h00,8'h00,0, 8'h11,8'h00,8'h01,8'h00));
        vecs.push_back(mk(8'h04,0,0,8'h00,8'h00,0,3'd7,0,0,8'h11,8'h00,0, 8'h04,8'h00,8'h01,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h04,8'h00,8'h04,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,1,8'h04,8'h04,0, 8'h00,8'h04,8'h04,8'h04));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h04,0, 8'h00,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h04,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h04,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h04,8'h00,8'h04,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,1,8'h00,8'h00,0, 8'h04,8'h04,8'h04,8'h04));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h04,8'h04,8'h00,8'h04));
        vecs.push_back(mk(8'h00,0,1,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h04,8'h04,8'h04,8'h04));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h04,8'h04,0, 8'h00,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h01,1,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h01,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h01,1,0,8'h00,8'h00,0,3'd7,1,0,8'h01,8'h00,0, 8'h00,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h01,1,0,8'h00,8'h00,0,3'd7,1,0,8'h00,8'h00,0, 8'h00,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h01,1,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h01,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'h01,1,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h01,8'h00,8'h01,8'h00));
        vecs.push_back(mk(8'h00,1,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'h00,8'h00,8'h01,8'h00));
        vecs.push_back(mk(8'hFF,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'hFF,8'h00,8'h00,8'h00));
        vecs.push_back(mk(8'hFF,0,0,8'h00,8'h00,0,3'd5,0,0,8'h00,8'h00,0, 8'hFF,8'h00,8'h40,8'h00));
        vecs.push_back(mk(8'hFF,0,0,8'h00,8'h00,0,3'd7,1,0,8'h00,8'h00,0, 8'hFF,8'h00,8'h40,8'h00));
        vecs.push_back(mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'hFF,8'h00,8'h01,8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("v%0d", i));
        end

        // Reinitialise while everything is busy, then show the edge detector restarted
        h = mk(8'h00,0,0,8'h00,8'h00,0,3'd7,0,1,8'h00,8'h00,0, 8'hFF,8'h01,8'h01,8'h01);
        applyStimulus(h); checkOutput(h, "icw_pre");
        h = mk(8'hFF,0,0,8'h00,8'h00,0,3'd7,0,1,8'h00,8'h00,1, 8'h00,8'h00,8'h00,8'h00);
        applyStimulus(h); checkOutput(h, "icw");
        h = mk(8'hFF,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'hFF,8'h00,8'h00,8'h00);
        applyStimulus(h); checkOutput(h, "icw_post1");
        h = mk(8'hFF,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'hFF,8'h00,8'h01,8'h00);
        applyStimulus(h); checkOutput(h, "icw_post2");
        h = mk(8'hFF,0,0,8'h00,8'h00,0,3'd7,0,1,8'h00,8'h00,0, 8'hFF,8'h01,8'h01,8'h01);
        applyStimulus(h); checkOutput(h, "ack");

        // Reset in the middle of an acknowledge: immediate clear, held through an edge
        #2 reset_n = 1'b0;
        #1 checkAllClear("rst_async");
        @(posedge clock); #1;
        checkAllClear("rst_hold");
        arb_bus.latch_in_service = 1'b0;
        #2 reset_n = 1'b1;
        h = mk(8'hFF,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'hFF,8'h00,8'h00,8'h00);
        applyStimulus(h); checkOutput(h, "rst_rel1");
        h = mk(8'hFF,0,0,8'h00,8'h00,0,3'd7,0,0,8'h00,8'h00,0, 8'hFF,8'h00,8'h01,8'h00);
        applyStimulus(h); checkOutput(h, "rst_rel2");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
